// File: rtl/avalon_mem_tester_pkg.sv
// Shared types and helpers for the Avalon-MM memory tester.
// Holds the run FSM encoding and the test pattern generator.
package mem_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int PAT_W = 64;

   // Index is zero-extended here; callers truncate to the bus width.
   function automatic logic [PAT_W-1:0] pattern(
      input logic [PAT_W-1:0] idx,
      input logic [PAT_W-1:0] seed
   );
      return idx ^ seed;
   endfunction

endpackage

// File: rtl/avalon_mem_tester_if.sv
// Avalon-MM master/slave bus bundle used by the memory tester.
// Command signals flow master -> slave, responses flow back.
interface avalon_mm_if #(
   parameter int AW = 24,
   parameter int DW = 16
);

   logic            avm_read;
   logic            avm_write;
   logic [AW-1:0]   avm_address;
   logic [DW-1:0]   avm_writedata;
   logic [DW/8-1:0] avm_byteenable;
   logic [DW-1:0]   avm_readdata;
   logic            avm_waitrequest;
   logic            avm_readdatavalid;

   modport master (
      output avm_read,
      output avm_write,
      output avm_address,
      output avm_writedata,
      output avm_byteenable,
      input  avm_readdata,
      input  avm_waitrequest,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_read,
      input  avm_write,
      input  avm_address,
      input  avm_writedata,
      input  avm_byteenable,
      output avm_readdata,
      output avm_waitrequest,
      output avm_readdatavalid
   );

endinterface

// File: rtl/avalon_mem_tester_rd_tracker.sv
// Read-side bookkeeping: in-flight read count and response index.
// The limit flag reflects next cycle's count so reads never overshoot.
module avalon_rd_tracker #(
   parameter int IW              = 25,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          rd_acc,
   input  logic          rsp,
   output logic [3:0]    outstanding,
   output logic [IW-1:0] chk_idx,
   output logic          limit
);

   logic [3:0] cnt_nxt;

   always_comb begin
      cnt_nxt = outstanding;
      unique case (1'b1)
         rd_acc & ~rsp:
            cnt_nxt = outstanding + 4'd1;
         rsp & ~rd_acc & (outstanding != 4'd0):
            cnt_nxt = outstanding - 4'd1;
         default: ;
      endcase
   end

   assign limit = cnt_nxt >= 4'(MAX_OUTSTANDING);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
         chk_idx     <= '0;
      end else if (clear) begin
         outstanding <= '0;
         chk_idx     <= '0;
      end else begin
         outstanding <= cnt_nxt;
         if (rsp)
            chk_idx <= chk_idx + IW'(1);
      end
   end

endmodule

// File: rtl/avalon_mem_tester.sv
// Avalon-MM memory tester: writes a seeded pattern, reads it back
// with a bounded read pipeline and counts mismatching words.
module avalon_mem_tester
   import mem_test_pkg::*;
#(
   parameter int          AVS_AW          = 24,
   parameter int          AVS_DW          = 16,
   parameter int          TEST_WORDS      = 1024,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int unsigned SEED            = 16'hA5C3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [AVS_AW-1:0] first_err_addr,
   avalon_mm_if.master       avm
);

   localparam int IW = AVS_AW + 1;
   localparam logic [AVS_DW-1:0] SEED_W   = AVS_DW'(SEED);
   localparam logic [IW-1:0]     LAST_IDX = IW'(TEST_WORDS - 1);
   localparam logic [IW-1:0]     END_IDX  = IW'(TEST_WORDS);

   function automatic logic [AVS_DW-1:0] pat(input logic [IW-1:0] i);
      return AVS_DW'(pattern(PAT_W'(i), PAT_W'(SEED_W)));
   endfunction

   state_t          state;
   logic [IW-1:0]   wr_idx;
   logic [IW-1:0]   rd_idx;
   logic [IW-1:0]   wr_nxt;
   logic [IW-1:0]   rd_nxt;
   logic [IW-1:0]   chk_idx;
   logic [3:0]      outstanding;
   logic            limit;
   logic            wr_acc;
   logic            rd_acc;
   logic            rsp;
   logic            launch;
   logic            mismatch;

   assign wr_nxt   = wr_idx + IW'(1);
   assign rd_nxt   = rd_idx + IW'(1);
   assign wr_acc   = avm.avm_write & ~avm.avm_waitrequest;
   assign rd_acc   = avm.avm_read & ~avm.avm_waitrequest;
   assign rsp      = avm.avm_readdatavalid &
                     ((state == ST_READ) | (state == ST_DRAIN));
   assign launch   = start & ((state == ST_IDLE) | (state == ST_DONE));
   assign mismatch = rsp & (avm.avm_readdata != pat(chk_idx));

   avalon_rd_tracker #(
      .IW              (IW),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_trk (
      .clk         (clk),
      .reset       (reset),
      .clear       (launch),
      .rd_acc      (rd_acc),
      .rsp         (rsp),
      .outstanding (outstanding),
      .chk_idx     (chk_idx),
      .limit       (limit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= ST_IDLE;
         wr_idx             <= '0;
         rd_idx             <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         pass               <= 1'b0;
         err_count          <= '0;
         first_err_addr     <= '0;
         avm.avm_read       <= 1'b0;
         avm.avm_write      <= 1'b0;
         avm.avm_address    <= '0;
         avm.avm_writedata  <= '0;
         avm.avm_byteenable <= '0;
      end else begin
         if (mismatch) begin
            if (err_count != 16'hFFFF)
               err_count <= err_count + 16'd1;
            if (err_count == 16'd0)
               first_err_addr <= chk_idx[AVS_AW-1:0];
         end
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state              <= ST_WRITE;
                  wr_idx             <= '0;
                  rd_idx             <= '0;
                  busy               <= 1'b1;
                  done               <= 1'b0;
                  pass               <= 1'b0;
                  err_count          <= '0;
                  first_err_addr     <= '0;
                  avm.avm_write      <= 1'b1;
                  avm.avm_address    <= '0;
                  avm.avm_writedata  <= pat('0);
                  avm.avm_byteenable <= '1;
               end
            end
            ST_WRITE: begin
               if (wr_acc) begin
                  if (wr_idx == LAST_IDX) begin
                     state           <= ST_READ;
                     avm.avm_write   <= 1'b0;
                     avm.avm_read    <= 1'b1;
                     avm.avm_address <= rd_idx[AVS_AW-1:0];
                  end else begin
                     wr_idx            <= wr_nxt;
                     avm.avm_address   <= wr_nxt[AVS_AW-1:0];
                     avm.avm_writedata <= pat(wr_nxt);
                  end
               end
            end
            ST_READ: begin
               if (rd_acc) begin
                  if (rd_idx == LAST_IDX) begin
                     state        <= ST_DRAIN;
                     avm.avm_read <= 1'b0;
                  end else begin
                     rd_idx          <= rd_nxt;
                     avm.avm_address <= rd_nxt[AVS_AW-1:0];
                     avm.avm_read    <= ~limit;
                  end
               end else if (!avm.avm_read) begin
                  avm.avm_read <= ~limit;
               end
            end
            ST_DRAIN: begin
               if ((outstanding == 4'd0) && (chk_idx == END_IDX)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == 16'd0);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_mem_tester.sv
// Directed bench for avalon_mem_tester with a behavioural Avalon slave.
// Covers clean runs, stalls, pipeline limit, errors and mid-run reset.
module tb_avalon_mem_tester;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [23:0] first_err_addr;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   avalon_mm_if #(.AW(24), .DW(16)) bus ();

   avalon_mem_tester #(
      .AVS_AW          (24),
      .AVS_DW          (16),
      .TEST_WORDS      (8),
      .MAX_OUTSTANDING (4),
      .SEED            (16'hA5C3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .avm            (bus.master)
   );

   typedef struct {
      logic [15:0] d;
      int          due;
   } rsp_t;

   int  lat = 1;
   bit  stall_en = 0;
   bit  corrupt_en = 0;
   rsp_t rq[$];
   logic [15:0] mem [0:7];
   int  cyc = 0;
   int  stall_used = 0;
   int  stall_n = 0;
   int  pend = 0;
   int  pmax = 0;
   int  omax = 0;
   int  rd_n = 0;
   bit  stall_bad = 0;
   bit  sim_arm = 0;
   bit  sim_seen = 0;
   bit  sim_bad = 0;
   logic [3:0]  sim_prev = '0;
   logic [23:0] wl_addr[$];
   logic [15:0] wl_data[$];
   int          wl_cyc[$];

   always_comb
      bus.avm_waitrequest = stall_en && bus.avm_write &&
                            (bus.avm_address == 24'd2) && (stall_used < 3);

   // Slave model plus bookkeeping of what crossed the bus.
   always @(posedge clk) begin
      logic        racc;
      logic        wacc;
      logic        rdv;
      logic [2:0]  a;
      logic [15:0] d;
      racc = bus.avm_read && !bus.avm_waitrequest;
      wacc = bus.avm_write && !bus.avm_waitrequest;
      rdv  = (bus.avm_readdatavalid === 1'b1);
      a    = bus.avm_address[2:0];
      cyc  = cyc + 1;
      if (start && !busy) begin
         wl_addr.delete();
         wl_data.delete();
         wl_cyc.delete();
         pend = 0; pmax = 0; omax = 0; rd_n = 0;
         stall_n = 0; stall_bad = 0;
         sim_seen = 0; sim_bad = 0; sim_arm = 0;
      end
      if (sim_arm) begin
         sim_seen = 1;
         if (dut.outstanding != sim_prev) sim_bad = 1;
      end
      sim_arm  = racc && rdv && busy;
      sim_prev = dut.outstanding;
      pend = pend + (racc ? 1 : 0) - ((rdv && busy) ? 1 : 0);
      if (pend > pmax) pmax = pend;
      if (int'(dut.outstanding) > omax) omax = int'(dut.outstanding);
      if (bus.avm_waitrequest) begin
         stall_n = stall_n + 1;
         if (bus.avm_address != 24'd2 || bus.avm_writedata != 16'hA5C1)
            stall_bad = 1;
      end
      if (!busy) stall_used = 0;
      else if (bus.avm_waitrequest) stall_used = stall_used + 1;
      if (wacc) begin
         mem[a] = bus.avm_writedata;
         wl_addr.push_back(bus.avm_address);
         wl_data.push_back(bus.avm_writedata);
         wl_cyc.push_back(cyc);
      end
      bus.avm_readdatavalid <= 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         bus.avm_readdata      <= rq[0].d;
         bus.avm_readdatavalid <= 1'b1;
         rq.delete(0);
      end
      if (racc) begin
         d = mem[a];
         if (corrupt_en && (a == 3'd3 || a == 3'd5)) d = d ^ 16'h0100;
         rq.push_back('{d, cyc + lat});
         rd_n = rd_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int poke);
      bit ok;
      ok = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 400; i++) begin
         start = (i == poke);
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      start = 1'b0;
      chk("run_done_in_time", 64'(ok), 64'd1);
   endtask

   initial begin
      logic [15:0] exp_wd [0:7];
      bit seq_ok;
      bit found;
      exp_wd[0] = 16'hA5C3; exp_wd[1] = 16'hA5C2;
      exp_wd[2] = 16'hA5C1; exp_wd[3] = 16'hA5C0;
      exp_wd[4] = 16'hA5C7; exp_wd[5] = 16'hA5C6;
      exp_wd[6] = 16'hA5C5; exp_wd[7] = 16'hA5C4;

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_err", 64'(err_count), 64'd0);
      chk("rst_first", 64'(first_err_addr), 64'd0);
      chk("rst_read", 64'(bus.avm_read), 64'd0);
      chk("rst_write", 64'(bus.avm_write), 64'd0);
      chk("rst_addr", 64'(bus.avm_address), 64'd0);
      chk("rst_wdata", 64'(bus.avm_writedata), 64'd0);
      chk("rst_be", 64'(bus.avm_byteenable), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // clean run, zero-wait slave, 1-cycle read latency
      lat = 1;
      run(-1);
      chk("clean_done", 64'(done), 64'd1);
      chk("clean_pass", 64'(pass), 64'd1);
      chk("clean_err", 64'(err_count), 64'd0);
      chk("clean_nwr", 64'(wl_data.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("clean_wd%0d", i), 64'(wl_data[i]), 64'(exp_wd[i]));
         chk($sformatf("clean_wa%0d", i), 64'(wl_addr[i]), 64'(i));
      end
      chk("clean_wr_span", 64'(wl_cyc[7] - wl_cyc[0]), 64'd7);
      chk("clean_nrd", 64'(rd_n), 64'd8);
      chk("sim_seen", 64'(sim_seen), 64'd1);
      chk("sim_outstanding_held", 64'(sim_bad), 64'd0);

      // stall on write index 2, with a start pulse while busy
      stall_en = 1;
      run(3);
      stall_en = 0;
      chk("stall_cycles", 64'(stall_n), 64'd3);
      chk("stall_stable", 64'(stall_bad), 64'd0);
      chk("stall_nwr", 64'(wl_data.size()), 64'd8);
      seq_ok = (wl_data.size() == 8);
      for (int i = 0; i < 8 && seq_ok; i++)
         if (wl_addr[i] != 24'(i) || wl_data[i] != exp_wd[i]) seq_ok = 0;
      chk("stall_seq", 64'(seq_ok), 64'd1);
      chk("stall_pass", 64'(pass), 64'd1);
      chk("busy_start_nrd", 64'(rd_n), 64'd8);

      // long-latency slave exercises the outstanding limit
      lat = 6;
      run(-1);
      chk("lim_bus_pending", 64'(pmax), 64'd4);
      chk("lim_outstanding", 64'(omax), 64'd4);
      chk("lim_nrd", 64'(rd_n), 64'd8);
      chk("lim_pass", 64'(pass), 64'd1);

      // corrupted words 3 and 5
      lat = 1;
      corrupt_en = 1;
      run(-1);
      corrupt_en = 0;
      chk("err_count", 64'(err_count), 64'd2);
      chk("err_first", 64'(first_err_addr), 64'd3);
      chk("err_pass", 64'(pass), 64'd0);
      chk("err_done", 64'(done), 64'd1);

      // reset in READ with two reads in flight
      lat = 6;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dut.outstanding == 4'd2 && !bus.avm_write && busy) begin
            found = 1;
            break;
         end
      end
      chk("mid_reached", 64'(found), 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_read", 64'(bus.avm_read), 64'd0);
      chk("mid_write", 64'(bus.avm_write), 64'd0);
      chk("mid_addr", 64'(bus.avm_address), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_outstanding", 64'(dut.outstanding), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("late_busy", 64'(busy), 64'd0);
      chk("late_done", 64'(done), 64'd0);
      chk("late_err", 64'(err_count), 64'd0);
      chk("late_chk_idx", 64'(dut.chk_idx), 64'd0);
      chk("late_outstanding", 64'(dut.outstanding), 64'd0);

      lat = 1;
      run(-1);
      chk("rerun_pass", 64'(pass), 64'd1);
      chk("rerun_err", 64'(err_count), 64'd0);
      chk("rerun_nwr", 64'(wl_data.size()), 64'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
